rgmii_rx_decode: RTL and testbench

RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

---
 rtl/rgmii_rx_decode.sv | 179 +++++++++++++++++
 tb/tb_rgmii_rx_decode.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns DDR nibble pairs into GMII-style bytes at all three
// speeds and debounces the in-band link status carried on RXD between frames.
module rgmii_rx_decode #(
   parameter int INBAND_STABLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] input_q1,
   input  logic [4:0] input_q2,
   input  logic [1:0] speed,
   output logic [7:0] gmii_rxd,
   output logic       gmii_rx_dv,
   output logic       gmii_rx_er,
   output logic       gmii_valid,
   output logic       odd_nibble,
   output logic       link_up,
   output logic [1:0] link_speed,
   output logic       link_full_duplex
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [3:0] LOAD_CNT = 4'(INBAND_STABLE - 1);

   logic       dv, er, gig, speed_change;
   logic [1:0] speed_norm;

   logic [1:0] state_reg, state_next;
   logic [3:0] nib_reg, nib_next;
   logic       er_acc_reg, er_acc_next;
   logic       phase_reg, phase_next;
   logic       squelch_reg, squelch_next;
   logic [1:0] speed_prev_reg;
   logic [7:0] rxd_reg, rxd_next;
   logic       dv_reg, dv_next;
   logic       er_reg, er_next;
   logic       valid_reg, valid_next;
   logic       odd_reg, odd_next;

   logic       ib_idle, ib_match, ib_load;
   logic [3:0] ib_prev_reg, ib_prev_next;
   logic [3:0] ib_cnt_reg, ib_cnt_next;
   logic       link_up_reg, link_fd_reg;
   logic [1:0] link_speed_reg;

   assign dv           = input_q1[4];
   assign er           = input_q1[4] ^ input_q2[4];
   assign gig          = speed[1];
   // Both 1000M encodings count as the same speed
   assign speed_norm   = gig ? 2'b10 : speed;
   assign speed_change = (speed_norm != speed_prev_reg);

   always_comb begin
      state_next   = state_reg;
      nib_next     = nib_reg;
      er_acc_next  = er_acc_reg;
      phase_next   = 1'b0;
      squelch_next = squelch_reg;
      rxd_next     = rxd_reg;
      dv_next      = 1'b0;
      er_next      = 1'b0;
      valid_next   = 1'b0;
      odd_next     = 1'b0;
      if (speed_change && (state_reg != ST_IDLE)) begin
         // Half-assembled byte is meaningless at the new rate; mute until the frame ends
         state_next   = ST_IDLE;
         nib_next     = 4'h0;
         er_acc_next  = 1'b0;
         squelch_next = dv;
      end else if (squelch_reg && dv) begin
         state_next = ST_IDLE;
      end else begin
         squelch_next = 1'b0;
         if (gig) begin
            state_next = ST_IDLE;
            rxd_next   = {input_q2[3:0], input_q1[3:0]};
            dv_next    = dv;
            er_next    = er;
            valid_next = 1'b1;
         end else begin
            case (state_reg)
               ST_LOW: begin
                  valid_next = 1'b1;
                  dv_next    = 1'b1;
                  if (dv) begin
                     rxd_next   = {input_q1[3:0], nib_reg};
                     er_next    = er_acc_reg | er;
                     state_next = ST_HIGH;
                  end else begin
                     rxd_next   = {4'h0, nib_reg};
                     er_next    = 1'b1;
                     odd_next   = 1'b1;
                     state_next = ST_IDLE;
                  end
               end
               ST_HIGH: begin
                  if (dv) begin
                     nib_next    = input_q1[3:0];
                     er_acc_next = er;
                     state_next  = ST_LOW;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
               default: begin
                  if (dv) begin
                     nib_next    = input_q1[3:0];
                     er_acc_next = er;
                     state_next  = ST_LOW;
                  end else begin
                     // Idle strobe at byte rate so false carrier still reaches the MAC
                     valid_next = ~phase_reg;
                     phase_next = ~phase_reg;
                     rxd_next   = {4'h0, input_q1[3:0]};
                     er_next    = er;
                  end
               end
            endcase
         end
      end
   end

   assign ib_idle      = ~input_q1[4] & ~input_q2[4];
   assign ib_match     = (input_q1[3:0] == ib_prev_reg);
   assign ib_prev_next = ib_idle ? input_q1[3:0] : ib_prev_reg;
   assign ib_cnt_next  = (ib_idle && ib_match) ?
                         ((ib_cnt_reg == 4'hF) ? 4'hF : ib_cnt_reg + 4'h1) : 4'h0;
   assign ib_load      = ib_idle && (ib_cnt_next == LOAD_CNT);

   always_ff @(posedge clk) begin
      speed_prev_reg <= speed_norm;
      if (rst) begin
         state_reg      <= ST_IDLE;
         nib_reg        <= 4'h0;
         er_acc_reg     <= 1'b0;
         phase_reg      <= 1'b0;
         squelch_reg    <= 1'b0;
         rxd_reg        <= 8'h00;
         dv_reg         <= 1'b0;
         er_reg         <= 1'b0;
         valid_reg      <= 1'b0;
         odd_reg        <= 1'b0;
         ib_prev_reg    <= 4'h0;
         ib_cnt_reg     <= 4'h0;
         link_up_reg    <= 1'b0;
         link_speed_reg <= 2'b00;
         link_fd_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         nib_reg     <= nib_next;
         er_acc_reg  <= er_acc_next;
         phase_reg   <= phase_next;
         squelch_reg <= squelch_next;
         rxd_reg     <= rxd_next;
         dv_reg      <= dv_next;
         er_reg      <= er_next;
         valid_reg   <= valid_next;
         odd_reg     <= odd_next;
         ib_prev_reg <= ib_prev_next;
         ib_cnt_reg  <= ib_cnt_next;
         if (ib_load) begin
            link_up_reg    <= input_q1[0];
            link_speed_reg <= input_q1[2:1];
            link_fd_reg    <= input_q1[3];
         end
      end
   end

   assign gmii_rxd         = rxd_reg;
   assign gmii_rx_dv       = dv_reg;
   assign gmii_rx_er       = er_reg;
   assign gmii_valid       = valid_reg;
   assign odd_nibble       = odd_reg;
   assign link_up          = link_up_reg;
   assign link_speed       = link_speed_reg;
   assign link_full_duplex = link_fd_reg;

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode; obs packs {valid,dv,er,odd,rxd}, lnk packs
// {link_up,link_speed,link_full_duplex}.
module tb_rgmii_rx_decode;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] q1, q2;
   logic [1:0] speed;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv, gmii_rx_er, gmii_valid, odd_nibble;
   logic       link_up, link_full_duplex;
   logic [1:0] link_speed;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rgmii_rx_decode #(.INBAND_STABLE(4)) dut (
      .clk(clk), .rst(rst), .input_q1(q1), .input_q2(q2), .speed(speed),
      .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
      .gmii_valid(gmii_valid), .odd_nibble(odd_nibble), .link_up(link_up),
      .link_speed(link_speed), .link_full_duplex(link_full_duplex)
   );

   wire [11:0] obs = {gmii_valid, gmii_rx_dv, gmii_rx_er, odd_nibble, gmii_rxd};
   wire [3:0]  lnk = {link_up, link_speed, link_full_duplex};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-14s = %h", tag, got);
      end else begin
         $display("FAIL %-14s got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next edge
   task automatic step(input logic [4:0] a, input logic [4:0] b);
      q1 = a;
      q2 = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; q1 = 5'h00; q2 = 5'h00; speed = 2'b01;
      step(5'h00, 5'h00);
      check("rst_obs", 16'(obs), 16'h000);
      check("rst_link", 16'(lnk), 16'h0);
      rst = 1'b0;

      // 1000M
      speed = 2'b10;
      step(5'h15, 5'h1A); check("g_a5", 16'(obs), 16'hCA5);
      step(5'h15, 5'h0A); check("g_er", 16'(obs), 16'hEA5);
      step(5'h00, 5'h00); check("g_idle", 16'(obs), 16'h800);

      // 100M idle strobe then nibbles 5,5,5,D
      speed = 2'b01;
      step(5'h00, 5'h00); check("idle_strobe", 16'(obs), 16'h800);
      step(5'h00, 5'h00); check("idle_gap", 16'(gmii_valid), 16'h0);
      step(5'h15, 5'h15); check("n1_gap", 16'(gmii_valid), 16'h0);
      step(5'h15, 5'h15); check("byte_55", 16'(obs), 16'hC55);
      step(5'h15, 5'h15); check("n3_gap", 16'(gmii_valid), 16'h0);
      step(5'h1D, 5'h1D); check("byte_d5", 16'(obs), 16'hCD5);
      step(5'h00, 5'h00); check("end_gap", 16'({gmii_valid, odd_nibble}), 16'h0);
      step(5'h00, 5'h00); check("post_idle", 16'(obs), 16'h800);

      // Odd nibble: 1,2,3 then dv low
      step(5'h11, 5'h11); check("o1_gap", 16'(gmii_valid), 16'h0);
      step(5'h12, 5'h12); check("byte_21", 16'(obs), 16'hC21);
      step(5'h13, 5'h13); check("o3_gap", 16'(gmii_valid), 16'h0);
      step(5'h00, 5'h00); check("byte_03_odd", 16'(obs), 16'hF03);
      step(5'h00, 5'h00); check("odd_once", 16'(obs), 16'h800);

      // Error on the low nibble carries into the byte
      step(5'h17, 5'h07);
      step(5'h18, 5'h18); check("byte_87_er", 16'(obs), 16'hE87);
      step(5'h00, 5'h00);

      // False carrier in idle
      step(5'h0E, 5'h1E); check("false_carr", 16'(obs), 16'hA0E);
      step(5'h0E, 5'h1E); check("fc_gap", 16'(gmii_valid), 16'h0);

      // Reset in the middle of a 100M frame
      step(5'h11, 5'h11);
      rst = 1'b1;
      step(5'h12, 5'h12); check("midrst_obs", 16'(obs), 16'h000);
      check("midrst_link", 16'(lnk), 16'h0);
      rst = 1'b0;
      step(5'h13, 5'h13); check("rr_gap", 16'({gmii_valid, odd_nibble}), 16'h0);
      step(5'h14, 5'h14); check("byte_43", 16'(obs), 16'hC43);
      step(5'h00, 5'h00);

      // 10M with one nibble stored, then switch to 1000M
      speed = 2'b00;
      step(5'h00, 5'h00);
      step(5'h16, 5'h16);
      speed = 2'b10;
      step(5'h17, 5'h17); check("sw_mute", 16'({gmii_valid, odd_nibble}), 16'h0);
      step(5'h15, 5'h1A); check("sw_mute2", 16'({gmii_valid, odd_nibble}), 16'h0);
      step(5'h00, 5'h00); check("sw_idle", 16'(obs), 16'h800);
      step(5'h15, 5'h1A); check("sw_a5", 16'(obs), 16'hCA5);

      // In-band status: RXD=D needs four consecutive idle cycles
      for (int i = 0; i < 3; i++) step(5'h0D, 5'h0D);
      check("ib_hold3", 16'(lnk), 16'h0);
      step(5'h0D, 5'h0D); check("ib_load_d", 16'(lnk), 16'hD);
      step(5'h0D, 5'h0D); check("ib_stay_d", 16'(lnk), 16'hD);
      step(5'h00, 5'h00); check("ib_break", 16'(lnk), 16'hD);
      for (int i = 0; i < 3; i++) step(5'h05, 5'h05);
      check("ib_restart3", 16'(lnk), 16'hD);
      step(5'h05, 5'h05); check("ib_load_5", 16'(lnk), 16'hC);
      // A frame cycle resets the counter
      step(5'h05, 5'h05);
      step(5'h15, 5'h15);
      for (int i = 0; i < 3; i++) step(5'h0D, 5'h0D);
      check("ib_nonidle3", 16'(lnk), 16'hC);
      step(5'h0D, 5'h0D); check("ib_load_d2", 16'(lnk), 16'hD);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
